// File: rtl/lab_pkg.sv
// lab_pkg: shared screen geometry, circle command bundle and scheduler state encoding.
package lab_pkg;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RELEASE, GAP} sched_state_t;
   typedef struct packed {
      logic [7:0] centre_x;
      logic [6:0] centre_y;
      logic [7:0] radius;
      logic [2:0] colour;
   } circle_cmd_t;
endpackage

// File: rtl/circle_draw_scheduler_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority pick of the first request after last.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last,
   output logic                 gnt_valid,
   output logic [$clog2(N)-1:0] gnt_id
);
   localparam int IW = $clog2(N);
   logic [IW-1:0] idx;
   // walk downward so the nearest slot after last is the final write
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id = '0;
      idx = '0;
      for (int k = N; k >= 1; k--) begin
         idx = IW'((int'(last) + k) % N);
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_id = idx;
         end
      end
   end
endmodule

// File: rtl/circle_draw_scheduler.sv
// circle_draw_scheduler: shares one circle engine between N_REQ one-deep command slots.
module circle_draw_scheduler
   import lab_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int GAP_CYCLES = 4,
   parameter int TIMEOUT_CYCLES = 2**20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [8*N_REQ-1:0]       req_centre_x,
   input  logic [7*N_REQ-1:0]       req_centre_y,
   input  logic [8*N_REQ-1:0]       req_radius,
   input  logic [3*N_REQ-1:0]       req_colour,
   output logic                     eng_start,
   input  logic                     eng_done,
   output logic [7:0]               eng_centre_x,
   output logic [6:0]               eng_centre_y,
   output logic [7:0]               eng_radius,
   output logic [2:0]               eng_colour,
   output logic                     cmpl_valid,
   output logic [$clog2(N_REQ)-1:0] cmpl_id,
   output logic                     cmpl_err,
   output logic                     busy,
   output logic                     err_timeout
);
   localparam int IW = $clog2(N_REQ);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
   sched_state_t state;
   circle_cmd_t slot [N_REQ];
   circle_cmd_t eng_cmd;
   logic [N_REQ-1:0] slot_full;
   logic [IW-1:0] last_grant, cur, gnt_id;
   logic gnt_valid, job_err, rel_done;
   logic [TW-1:0] wd_cnt;
   logic [GW-1:0] gap_cnt;
   assign req_ready = ~slot_full;
   assign busy = (state != IDLE) || (|slot_full);
   assign {eng_centre_x, eng_centre_y, eng_radius, eng_colour} = eng_cmd;
   // a timed-out engine may never drop done, so an errored job leaves without waiting
   assign rel_done = (state == RELEASE) && (job_err || !eng_done);
   rr_arbiter #(.N(N_REQ)) u_arb (
      .req(slot_full),
      .last(last_grant),
      .gnt_valid(gnt_valid),
      .gnt_id(gnt_id)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_full <= '0;
         slot <= '{default: '0};
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && !slot_full[i]) begin
               slot_full[i] <= 1'b1;
               slot[i] <= '{centre_x: req_centre_x[8*i +: 8], centre_y: req_centre_y[7*i +: 7],
                            radius: req_radius[8*i +: 8], colour: req_colour[3*i +: 3]};
            end else if (rel_done && cur == IW'(i)) begin
               slot_full[i] <= 1'b0;
            end
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         eng_start <= 1'b0;
         eng_cmd <= '0;
         cmpl_valid <= 1'b0;
         cmpl_id <= '0;
         cmpl_err <= 1'b0;
         err_timeout <= 1'b0;
         last_grant <= IW'(N_REQ - 1);
         cur <= '0;
         job_err <= 1'b0;
         wd_cnt <= '0;
         gap_cnt <= '0;
      end else begin
         cmpl_valid <= 1'b0;
         case (state)
            IDLE: if (gnt_valid) begin
               eng_cmd <= slot[gnt_id];
               eng_start <= 1'b1;
               cur <= gnt_id;
               last_grant <= gnt_id;
               job_err <= 1'b0;
               state <= ISSUE;
            end
            ISSUE: begin
               wd_cnt <= '0;
               state <= WAIT_DONE;
            end
            WAIT_DONE: if (eng_done) begin
               eng_start <= 1'b0;
               state <= RELEASE;
            end else if (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               eng_start <= 1'b0;
               err_timeout <= 1'b1;
               job_err <= 1'b1;
               state <= RELEASE;
            end else begin
               wd_cnt <= wd_cnt + 1'b1;
            end
            RELEASE: if (rel_done) begin
               cmpl_valid <= 1'b1;
               cmpl_id <= cur;
               cmpl_err <= job_err;
               gap_cnt <= '0;
               state <= (GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP: if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= IDLE;
                 else gap_cnt <= gap_cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
